// File: rtl/axis_pkt_tx.sv
// AXI-Stream packet generator: one command (seed, length) becomes an
// incrementing-data packet, optionally followed by a fixed idle gap.
module axis_pkt_tx #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned LWIDTH = 8,
    parameter int unsigned INC    = 1,
    parameter int unsigned GAP    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DWIDTH-1:0] cmd_seed,
    input  logic [LWIDTH-1:0] cmd_len,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              pkt_done,
    output logic [15:0]       pkt_cnt
);

    localparam int unsigned GWIDTH = (GAP > 1) ? $clog2(GAP) : 1;
    localparam bit          HAS_GAP = (GAP != 0);
    localparam logic [DWIDTH-1:0] INC_D    = DWIDTH'(INC);
    localparam logic [GWIDTH-1:0] GAP_LOAD = GWIDTH'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            state;
    logic [LWIDTH-1:0] remaining;
    logic [GWIDTH-1:0] gap_cnt;

    assign cmd_ready = (state == ST_IDLE);

    // remaining counts handshakes still owed after the beat on the bus;
    // the beat presented while it is zero is the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            gap_cnt   <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            busy      <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_cnt   <= 16'd0;
        end else begin
            pkt_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state     <= ST_SEND;
                        busy      <= 1'b1;
                        m_valid   <= 1'b1;
                        m_data    <= cmd_seed;
                        m_last    <= (cmd_len == '0);
                        remaining <= cmd_len;
                    end
                end
                ST_SEND: begin
                    if (m_ready) begin
                        if (m_last) begin
                            m_valid  <= 1'b0;
                            m_last   <= 1'b0;
                            pkt_done <= 1'b1;
                            pkt_cnt  <= pkt_cnt + 16'd1;
                            if (HAS_GAP) begin
                                state   <= ST_GAP;
                                gap_cnt <= GAP_LOAD;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            m_data    <= m_data + INC_D;
                            remaining <= remaining - LWIDTH'(1);
                            m_last    <= (remaining == LWIDTH'(1));
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - GWIDTH'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pkt_tx.sv
// Directed bench for axis_pkt_tx: scoreboarded beats on a GAP=0 instance,
// gap timing on a second GAP=3 instance.
module tb_axis_pkt_tx;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, m_valid, m_ready, m_last, busy, pkt_done;
    logic [7:0]  cmd_seed, cmd_len, m_data;
    logic [15:0] pkt_cnt;

    logic        g_cmd_valid, g_cmd_ready, g_m_valid, g_m_ready, g_m_last, g_busy, g_pkt_done;
    logic [7:0]  g_cmd_seed, g_cmd_len, g_m_data;
    logic [15:0] g_pkt_cnt;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_hs     = 0;
    int    n_done   = 0;
    beat_t sb_q[$];

    always #5 clk = ~clk;

    axis_pkt_tx #(.DWIDTH(8), .LWIDTH(8), .INC(1), .GAP(0)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_seed(cmd_seed), .cmd_len(cmd_len),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .pkt_done(pkt_done), .pkt_cnt(pkt_cnt)
    );

    axis_pkt_tx #(.DWIDTH(8), .LWIDTH(8), .INC(1), .GAP(3)) u_gap (
        .clk(clk), .rst(rst),
        .cmd_valid(g_cmd_valid), .cmd_ready(g_cmd_ready),
        .cmd_seed(g_cmd_seed), .cmd_len(g_cmd_len),
        .m_valid(g_m_valid), .m_ready(g_m_ready), .m_data(g_m_data), .m_last(g_m_last),
        .busy(g_busy), .pkt_done(g_pkt_done), .pkt_cnt(g_pkt_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: sampled mid-cycle, so m_valid && m_ready means a handshake on the next edge.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(m_valid), 32'd1);
                chk("stall_data", 32'(m_data), 32'(prev_data));
                chk("stall_last", 32'(m_last), 32'(prev_last));
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (pkt_done === 1'b1) n_done++;
            if (m_valid && m_ready) begin
                n_hs++;
                chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    beat_t e;
                    e = sb_q.pop_front();
                    chk("beat_data", 32'(m_data), 32'(e.data));
                    chk("beat_last", 32'(m_last), 32'(e.last));
                end
            end
        end
    end

    task automatic push_pkt(input logic [7:0] seed, input logic [7:0] len);
        for (int i = 0; i <= int'(len); i++) begin
            beat_t b;
            b.data = 8'(seed + 8'(i));
            b.last = (i == int'(len));
            sb_q.push_back(b);
        end
    endtask

    task automatic send(input logic [7:0] seed, input logic [7:0] len);
        int n;
        push_pkt(seed, len);
        cmd_valid = 1'b1;
        cmd_seed  = seed;
        cmd_len   = len;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("first_valid", 32'(m_valid), 32'd1);
        chk("first_data", 32'(m_data), 32'(seed));
        chk("first_last", 32'(m_last), 32'(len == 8'd0));
    endtask

    task automatic wait_done(input string tag, input int exp_cycles, input bit rnd);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; n++;
            if (pkt_done === 1'b1) seen = 1'b1;
        end
        m_ready = 1'b1;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (exp_cycles > 0) chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        int hs0;
        int done0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_seed = 8'h0; cmd_len = 8'h0; m_ready = 1'b0;
        g_cmd_valid = 1'b0; g_cmd_seed = 8'h0; g_cmd_len = 8'h0; g_m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pkt_done", 32'(pkt_done), 32'd0);
        chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_no_valid", 32'(m_valid), 32'd0);

        // Back-to-back burst with full throughput.
        send(8'h10, 8'd3);
        wait_done("pkt_10", 4, 1'b0);
        chk("pkt_10_cnt", 32'(pkt_cnt), 32'd1);
        chk("pkt_10_valid_off", 32'(m_valid), 32'd0);
        chk("pkt_10_last_off", 32'(m_last), 32'd0);
        chk("pkt_10_ready_now", 32'(cmd_ready), 32'd1);
        chk("pkt_10_busy_off", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("pkt_10_done_pulse", 32'(pkt_done), 32'd0);

        // Data wrap.
        send(8'hFE, 8'd2);
        wait_done("pkt_fe", 3, 1'b0);
        chk("pkt_fe_cnt", 32'(pkt_cnt), 32'd2);

        // Random backpressure.
        hs0 = n_hs;
        send(8'h40, 8'd4);
        wait_done("pkt_40", 0, 1'b1);
        @(posedge clk); #1;
        chk("pkt_40_handshakes", 32'(n_hs - hs0), 32'd5);
        chk("pkt_40_cnt", 32'(pkt_cnt), 32'd3);

        // Single beat.
        send(8'h77, 8'd0);
        wait_done("pkt_77", 1, 1'b0);
        chk("pkt_77_cnt", 32'(pkt_cnt), 32'd4);

        // cmd_valid held across two packets; command changes mid-packet.
        @(posedge clk); #1;
        push_pkt(8'h80, 8'd1);
        cmd_valid = 1'b1; cmd_seed = 8'h80; cmd_len = 8'd1;
        @(posedge clk); #1;
        chk("held_first_data", 32'(m_data), 32'h80);
        chk("held_send_ready0", 32'(cmd_ready), 32'd0);
        cmd_seed = 8'hA0; cmd_len = 8'd2;
        push_pkt(8'hA0, 8'd2);
        @(posedge clk); #1;
        chk("held_send_ready1", 32'(cmd_ready), 32'd0);
        chk("held_last_beat", 32'(m_last), 32'd1);
        @(posedge clk); #1;
        chk("held_done", 32'(pkt_done), 32'd1);
        chk("held_idle_ready", 32'(cmd_ready), 32'd1);
        chk("held_cnt1", 32'(pkt_cnt), 32'd5);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("held_second_valid", 32'(m_valid), 32'd1);
        chk("held_second_data", 32'(m_data), 32'hA0);
        wait_done("held_second", 3, 1'b0);
        chk("held_cnt2", 32'(pkt_cnt), 32'd6);

        // GAP=3 instance: single beat, then gap, held command waits.
        g_cmd_valid = 1'b1; g_cmd_seed = 8'h55; g_cmd_len = 8'd0;
        @(posedge clk); #1;
        chk("gap_beat_valid", 32'(g_m_valid), 32'd1);
        chk("gap_beat_data", 32'(g_m_data), 32'h55);
        chk("gap_beat_last", 32'(g_m_last), 32'd1);
        g_cmd_seed = 8'h66;
        @(posedge clk); #1;
        chk("gap_done", 32'(g_pkt_done), 32'd1);
        chk("gap_cnt1", 32'(g_pkt_cnt), 32'd1);
        chk("gap_ready_d0", 32'(g_cmd_ready), 32'd0);
        chk("gap_valid_off", 32'(g_m_valid), 32'd0);
        for (int i = 1; i < 3; i++) begin
            @(posedge clk); #1;
            chk($sformatf("gap_ready_d%0d", i), 32'(g_cmd_ready), 32'd0);
            chk("gap_busy", 32'(g_busy), 32'd1);
        end
        @(posedge clk); #1;
        chk("gap_ready_back", 32'(g_cmd_ready), 32'd1);
        chk("gap_busy_off", 32'(g_busy), 32'd0);
        @(posedge clk); #1;
        g_cmd_valid = 1'b0;
        chk("gap_second_data", 32'(g_m_data), 32'h66);
        @(posedge clk); #1;
        chk("gap_cnt2", 32'(g_pkt_cnt), 32'd2);

        // Reset mid-packet.
        done0 = n_done;
        send(8'h20, 8'd5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_beat2", 32'(m_data), 32'h22);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_valid", 32'(m_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cnt", 32'(pkt_cnt), 32'd0);
        chk("abort_done", 32'(pkt_done), 32'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(n_done - done0), 32'd0);
        chk("abort_still_idle", 32'(m_valid), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd1);

        send(8'h30, 8'd1);
        wait_done("recover", 2, 1'b0);
        chk("recover_cnt", 32'(pkt_cnt), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("total_done_pulses", 32'(n_done), 32'd7);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_pkt_tx.md
AXIS_PKT_TX -- requirements
Module: axis_pkt_tx

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: data width of cmd_seed and m_data.
REQ-002 SHALL have parameter LWIDTH, default 8: width of cmd_len.
REQ-003 SHALL have parameter INC, default 1: per-beat data increment.
REQ-004 SHALL have parameter GAP, default 0: idle cycles inserted after each packet.
REQ-005 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port cmd_valid  input  1  packet command offered.
REQ-008 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-009 SHALL have port cmd_seed  input  DWIDTH  first-beat data value.
REQ-010 SHALL have port cmd_len  input  LWIDTH  beats minus one (0 = 1 beat).
REQ-011 SHALL have port m_valid  output  1  stream beat valid.
REQ-012 SHALL have port m_ready  input  1  downstream ready.
REQ-013 SHALL have port m_data  output  DWIDTH  beat data.
REQ-014 SHALL have port m_last  output  1  final beat of packet.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port pkt_done  output  1  one-cycle pulse per completed packet.
REQ-017 SHALL have port pkt_cnt  output  16  completed-packet count, wraps 0xFFFF->0.

Function
REQ-018 SHALL implement FSM states IDLE, SEND, GAP.
REQ-019 SHALL drive cmd_ready = 1 only in IDLE, 0 otherwise; cmd_ready combinational from state only.
REQ-020 SHALL, on cmd_valid && cmd_ready, latch cmd_seed/cmd_len, enter SEND, and present m_valid=1, m_data=cmd_seed, m_last=(cmd_len==0) on the next cycle (1-cycle latency).
REQ-021 SHALL register m_valid, m_data, m_last (no combinational path from m_ready or cmd_* to them).
REQ-022 SHALL hold m_valid high and m_data/m_last stable while m_valid && !m_ready.
REQ-023 SHALL, on handshake (m_valid && m_ready) of a non-last beat, advance m_data by INC modulo 2^DWIDTH (wrap, no saturation) and decrement remaining count; m_last=1 exactly on beat cmd_len+1.
REQ-024 SHALL, on handshake of the last beat, deassert m_valid and m_last next cycle, pulse pkt_done for exactly that one cycle, increment pkt_cnt the same cycle.
REQ-025 SHALL go SEND->IDLE after last handshake when GAP==0; SEND->GAP when GAP>0, remain in GAP exactly GAP cycles, then IDLE.
REQ-026 SHALL ignore cmd_valid outside IDLE (no queuing); a held cmd_valid is accepted on first IDLE cycle.
REQ-027 SHALL emit total cmd_len+1 beats; cmd_len = 2^LWIDTH-1 SHALL yield 2^LWIDTH beats without counter overflow.
REQ-028 SHALL leave m_ready ignored when m_valid=0; no beat emitted.
REQ-029 SHALL sustain one beat per cycle while m_ready stays high; minimum one cycle between last beat handshake and next cmd acceptance (GAP=0).

Reset
REQ-030 SHALL, on rst, enter IDLE and drive m_valid=0, m_data=0, m_last=0, busy=0, pkt_done=0, pkt_cnt=0; cmd_ready=1 the first cycle after rst deasserts.
REQ-031 SHALL, on rst mid-packet or in GAP, abort immediately: no further beats, no pkt_done, pkt_cnt cleared.

Verification
REQ-032 SHALL cover: seed=0x10, len=3, m_ready=1 -> beats 0x10,0x11,0x12,0x13 on consecutive cycles, m_last only on 0x13, pkt_done once, pkt_cnt=1.
REQ-033 SHALL cover: seed=0xFE, len=2, INC=1 -> 0xFE,0xFF,0x00 (wrap), m_last on 0x00.
REQ-034 SHALL cover: len=4, m_ready toggling randomly -> m_data/m_last stable during every stall, exactly 5 handshakes, sequence unbroken.
REQ-035 SHALL cover: len=0 -> single beat with m_last=1; GAP=3 -> cmd_ready low 3 cycles after the pkt_done cycle... then high.
REQ-036 SHALL cover: cmd_valid held high across two packets -> second accepted first IDLE cycle, pkt_cnt=2; cmd_valid during SEND never accepted.
REQ-037 SHALL cover: rst asserted on beat 2 of len=5 -> next cycle m_valid=0, busy=0, pkt_cnt=0, no pkt_done.
